// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges single-cycle ALU results with buffered
// long-latency results and tracks pending long-latency destinations for decode stall.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_alu_valid,
    input  logic [ADDR_W-1:0]             i_alu_reg,
    input  logic [DATA_W-1:0]             i_alu_data,
    input  logic                          i_lsu_valid,
    input  logic [ADDR_W-1:0]             i_lsu_reg,
    input  logic [DATA_W-1:0]             i_lsu_data,
    output logic                          o_lsu_ready,
    input  logic                          i_issue_valid,
    input  logic [ADDR_W-1:0]             i_issue_reg,
    input  logic [ADDR_W-1:0]             i_chk_reg1,
    input  logic [ADDR_W-1:0]             i_chk_reg2,
    output logic                          o_stall,
    output logic                          o_reg_write,
    output logic [ADDR_W-1:0]             o_write_register,
    output logic [DATA_W-1:0]             o_write_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [NREG-1:0]   ONE_C    = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [NREG-1:0]   NO_R0_C  = {{(NREG-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] R0_C     = {ADDR_W{1'b0}};

    logic [ADDR_W-1:0] r_fifo_reg  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [NREG-1:0]   r_busy;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_register;
    logic [DATA_W-1:0] r_write_data;

    logic              w_lsu_ready;
    logic              w_xfer;
    logic              w_fifo_empty;
    logic              w_alu_sel;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic              w_sel_valid;
    logic [ADDR_W-1:0] w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_clr_mask;
    logic [NREG-1:0]   w_busy_next;
    logic [CW-1:0]     w_count_next;

    // Handshake and source-select qualifiers; ready is based only on the registered count.
    always_comb begin
        w_lsu_ready  = (r_count != DEPTH_C);
        w_xfer       = i_lsu_valid && w_lsu_ready;
        w_fifo_empty = (r_count == {CW{1'b0}});
        w_alu_sel    = i_alu_valid && (i_alu_reg != R0_C);
        w_pop        = !w_alu_sel && !w_fifo_empty;
        // Results to r0 complete the handshake but are never stored or written.
        w_bypass     = !w_alu_sel && w_fifo_empty && w_xfer && (i_lsu_reg != R0_C);
        w_push       = w_xfer && (i_lsu_reg != R0_C) && !w_bypass;
    end

    // Select the entry for the write port and the scoreboard bit it retires.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_reg   = r_write_register;
        w_sel_data  = r_write_data;
        w_clr_mask  = {NREG{1'b0}};
        if (w_alu_sel) begin
            w_sel_valid = 1'b1;
            w_sel_reg   = i_alu_reg;
            w_sel_data  = i_alu_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_reg   = r_fifo_reg[r_rptr];
            w_sel_data  = r_fifo_data[r_rptr];
            w_clr_mask  = ONE_C << r_fifo_reg[r_rptr];
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel_reg   = i_lsu_reg;
            w_sel_data  = i_lsu_data;
            w_clr_mask  = ONE_C << i_lsu_reg;
        end else begin
            w_sel_valid = 1'b0;
        end
    end

    // Next scoreboard mask (a same-edge set overrides the clear) and next FIFO occupancy.
    always_comb begin
        w_set_mask = {NREG{1'b0}};
        if (i_issue_valid && (i_issue_reg != R0_C)) begin
            w_set_mask = ONE_C << i_issue_reg;
        end else begin
            w_set_mask = {NREG{1'b0}};
        end
        w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & NO_R0_C;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // FIFO pointers, occupancy, scoreboard and the registered write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr           <= {PW{1'b0}};
            r_rptr           <= {PW{1'b0}};
            r_count          <= {CW{1'b0}};
            r_busy           <= {NREG{1'b0}};
            r_reg_write      <= 1'b0;
            r_write_register <= {ADDR_W{1'b0}};
            r_write_data     <= {DATA_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end else begin
                r_rptr <= r_rptr;
            end
            r_count          <= w_count_next;
            r_busy           <= w_busy_next;
            r_reg_write      <= w_sel_valid;
            r_write_register <= w_sel_reg;
            r_write_data     <= w_sel_data;
        end
    end

    // FIFO storage; contents are only meaningful under the pointers, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_reg[r_wptr]  <= i_lsu_reg;
            r_fifo_data[r_wptr] <= i_lsu_data;
        end else begin
            r_fifo_reg[r_wptr]  <= r_fifo_reg[r_wptr];
            r_fifo_data[r_wptr] <= r_fifo_data[r_wptr];
        end
    end

    assign o_lsu_ready      = w_lsu_ready;
    assign o_stall          = r_busy[i_chk_reg1] | r_busy[i_chk_reg2];
    assign o_reg_write      = r_reg_write;
    assign o_write_register = r_write_register;
    assign o_write_data     = r_write_data;
    assign o_fifo_count     = r_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a scoreboard queue holds the expected register-file
// writes in emission order; port-level checks cover handshake, occupancy and stall.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, issue_valid;
    logic [4:0]  alu_reg, lsu_reg, issue_reg, chk_reg1, chk_reg2;
    logic [31:0] alu_data, lsu_data;
    logic        lsu_ready, stall, reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [2:0]  fifo_count;

    logic [36:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_alu_valid(alu_valid), .i_alu_reg(alu_reg), .i_alu_data(alu_data),
        .i_lsu_valid(lsu_valid), .i_lsu_reg(lsu_reg), .i_lsu_data(lsu_data),
        .o_lsu_ready(lsu_ready),
        .i_issue_valid(issue_valid), .i_issue_reg(issue_reg),
        .i_chk_reg1(chk_reg1), .i_chk_reg2(chk_reg2),
        .o_stall(stall), .o_reg_write(reg_write),
        .o_write_register(write_register), .o_write_data(write_data),
        .o_fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_reg = 5'd0; lsu_data = 32'd0;
        issue_valid = 1'b0; issue_reg = 5'd0;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        alu_valid = 1'b1; alu_reg = r; alu_data = d;
    endtask

    task automatic lsu(input logic [4:0] r, input logic [31:0] d);
        lsu_valid = 1'b1; lsu_reg = r; lsu_data = d;
    endtask

    // Every write strobe seen on the register-file port must match the next expected entry.
    always @(negedge clk) begin
        if (reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'd0, 27'd0, write_register}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("write_port", {27'd0, write_register, write_data}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1; chk_reg1 = 5'd0; chk_reg2 = 5'd0;
        tick(); tick();
        check("rst_reg_write", reg_write, 1'b0);
        check("rst_write_register", write_register, 5'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_fifo_count", fifo_count, 3'd0);
        check("rst_lsu_ready", lsu_ready, 1'b1);
        check("rst_stall", stall, 1'b0);
        rst = 1'b0;
        tick();

        // 1: single ALU write, one-cycle latency
        alu(5'd5, 32'hDEADBEEF); exp_q.push_back({5'd5, 32'hDEADBEEF});
        tick();
        check("t1_reg_write", reg_write, 1'b1);
        check("t1_write_register", write_register, 5'd5);
        check("t1_write_data", write_data, 32'hDEADBEEF);
        idle();
        tick();
        check("t1_reg_write_off", reg_write, 1'b0);
        check("t1_addr_hold", write_register, 5'd5);

        // 2: ALU wins, concurrent LSU result is buffered then drained
        alu(5'd3, 32'h11); lsu(5'd4, 32'h22);
        exp_q.push_back({5'd3, 32'h11}); exp_q.push_back({5'd4, 32'h22});
        tick();
        check("t2_first_reg", write_register, 5'd3);
        check("t2_count1", fifo_count, 3'd1);
        check("t2_ready1", lsu_ready, 1'b1);
        idle();
        tick();
        check("t2_second_reg", write_register, 5'd4);
        check("t2_count0", fifo_count, 3'd0);
        check("t2_ready0", lsu_ready, 1'b1);
        tick();
        check("t2_idle", reg_write, 1'b0);

        // 3: ALU holds the port for 8 cycles, FIFO fills, r14 waits for space
        for (int c = 0; c < 8; c++) exp_q.push_back({5'd1, 32'h100 + 32'(c)});
        for (int k = 0; k < 5; k++) exp_q.push_back({5'(10 + k), 32'hA0 + 32'(k)});
        for (int c = 0; c < 10; c++) begin
            if (c < 8) alu(5'd1, 32'h100 + 32'(c)); else alu_valid = 1'b0;
            if (c < 4) lsu(5'(10 + c), 32'hA0 + 32'(c)); else lsu(5'd14, 32'hA4);
            if (c >= 4) check("t3_ready", lsu_ready, (c == 9) ? 1'b1 : 1'b0);
            tick();
            if (c == 3) check("t3_full_count", fifo_count, 3'd4);
        end
        idle();
        check("t3_count_after_r14", fifo_count, 3'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_drain_count", fifo_count, 3'(2 - k));
        end
        tick();
        check("t3_idle", reg_write, 1'b0);

        // 4: scoreboard stall, clear on bypass write, set wins over clear
        issue_valid = 1'b1; issue_reg = 5'd7; chk_reg1 = 5'd7;
        tick();
        idle();
        check("t4_stall_set", stall, 1'b1);
        chk_reg1 = 5'd0; chk_reg2 = 5'd7;
        check("t4_stall_chk2", stall, 1'b1);
        lsu(5'd7, 32'h55); exp_q.push_back({5'd7, 32'h55});
        tick();
        check("t4_bypass_write", reg_write, 1'b1);
        check("t4_stall_clear", stall, 1'b0);
        idle();
        issue_valid = 1'b1; issue_reg = 5'd7;
        tick();
        lsu(5'd7, 32'h66); exp_q.push_back({5'd7, 32'h66});
        tick();
        check("t4_set_wins_write", write_data, 32'h66);
        check("t4_set_wins_stall", stall, 1'b1);
        idle();
        lsu(5'd7, 32'h77); exp_q.push_back({5'd7, 32'h77});
        tick();
        check("t4_final_clear", stall, 1'b0);
        idle(); chk_reg2 = 5'd0;
        tick();

        // 5: writes to r0 are dropped, LSU handshake still completes
        alu(5'd0, 32'h1); lsu(5'd0, 32'h2);
        check("t5_ready", lsu_ready, 1'b1);
        tick();
        idle();
        check("t5_no_write", reg_write, 1'b0);
        check("t5_count", fifo_count, 3'd0);
        tick();
        check("t5_no_write2", reg_write, 1'b0);

        // 6: reset drops buffered entries and the scoreboard
        issue_valid = 1'b1; issue_reg = 5'd9; chk_reg1 = 5'd9;
        for (int c = 0; c < 3; c++) begin
            alu(5'd1, 32'h200 + 32'(c)); exp_q.push_back({5'd1, 32'h200 + 32'(c)});
            lsu(5'(20 + c), 32'h300 + 32'(c));
            tick();
            issue_valid = 1'b0;
        end
        idle();
        check("t6_buffered", fifo_count, 3'd3);
        check("t6_stall_before", stall, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_count", fifo_count, 3'd0);
        check("t6_ready", lsu_ready, 1'b1);
        check("t6_stall", stall, 1'b0);
        check("t6_reg_write", reg_write, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t6_no_write", reg_write, 1'b0);
        end

        @(negedge clk);
        check("pending_expected_writes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
